// File: rtl/alu_result_buffer.sv
// Result FIFO behind the combinational ALU: captures {op, y} plus zero/neg status
// (and parity when ALU_RESBUF_PARITY_EN is defined) and serves them first-word fall-through.
module alu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPW-1:0]             in_op,
  input  logic [WIDTH-1:0]           in_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPW-1:0]             out_op,
  output logic [WIDTH-1:0]           out_y,
  output logic                       out_zero,
  output logic                       out_neg,
  output logic                       out_parity,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [OPW-1:0]   mem_op [DEPTH];
  logic [WIDTH-1:0] mem_y  [DEPTH];
  logic [DEPTH-1:0] mem_zero;
  logic [DEPTH-1:0] mem_neg;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Handshake depends on count alone, never on the partner's valid/ready.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_op[i] <= '0;
        mem_y[i]  <= '0;
      end
      mem_zero <= '0;
      mem_neg  <= '0;
    end else if (push) begin
      mem_op[wr_ptr]   <= in_op;
      mem_y[wr_ptr]    <= in_y;
      mem_zero[wr_ptr] <= (in_y == '0);
      mem_neg[wr_ptr]  <= in_y[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_op   = mem_op[rd_ptr];
  assign out_y    = mem_y[rd_ptr];
  assign out_zero = mem_zero[rd_ptr];
  assign out_neg  = mem_neg[rd_ptr];

`ifdef ALU_RESBUF_PARITY_EN
  logic [DEPTH-1:0] mem_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       mem_par         <= '0;
    else if (push) mem_par[wr_ptr] <= ^in_y;
  end

  assign out_parity = mem_par[rd_ptr];
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer with a queue scoreboard of accepted results.
module tb_alu_result_buffer;

  localparam int WIDTH = 32;
  localparam int OPW   = 3;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_op;
  logic [WIDTH-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [OPW-1:0]   out_op;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_neg;
  logic             out_parity;
  logic [2:0]       count;

  typedef struct packed {
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] y;
  } entry_t;

  entry_t      sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  alu_result_buffer #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_y(out_y),
    .out_zero(out_zero), .out_neg(out_neg), .out_parity(out_parity), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_parity(input logic [WIDTH-1:0] y);
`ifdef ALU_RESBUF_PARITY_EN
    return ^y;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive, check handshake and head before the edge, update scoreboard, check count after.
  task automatic cycle(input logic v, input logic [OPW-1:0] op, input logic [WIDTH-1:0] y,
                       input logic r);
    entry_t e;
    logic   p;
    logic   q;
    in_valid  = v;
    in_op     = op;
    in_y      = y;
    out_ready = r;
    #1;
    chk("in_ready",  64'(in_ready),  64'(sb.size() != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    p = v && (sb.size() != DEPTH);
    q = r && (sb.size() != 0);
    if (q) begin
      e = sb.pop_front();
      chk("out_y",      64'(out_y),      64'(e.y));
      chk("out_op",     64'(out_op),     64'(e.op));
      chk("out_zero",   64'(out_zero),   64'(e.y == '0));
      chk("out_neg",    64'(out_neg),    64'(e.y[WIDTH-1]));
      chk("out_parity", 64'(out_parity), 64'(exp_parity(e.y)));
    end
    if (p) sb.push_back(entry_t'{op: op, y: y});
    @(posedge clk);
    #1;
    chk("count", 64'(count), 64'(sb.size()));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"},     64'(count),      64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid),  64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),   64'd1);
    chk({tag, "_out_y"},     64'(out_y),      64'd0);
    chk({tag, "_out_op"},    64'(out_op),     64'd0);
    chk({tag, "_out_zero"},  64'(out_zero),   64'd0);
    chk({tag, "_out_neg"},   64'(out_neg),    64'd0);
    chk({tag, "_out_par"},   64'(out_parity), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_y      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst = 1'b0;

    // Empty: popping does nothing; a push is not visible before its edge.
    cycle(1'b0, 3'd0, 32'h0, 1'b1);
    cycle(1'b0, 3'd0, 32'h0, 1'b1);
    cycle(1'b1, 3'd5, 32'h0000_1234, 1'b1);
    chk("fwft_valid", 64'(out_valid), 64'd1);
    chk("fwft_y",     64'(out_y),     64'h1234);
    cycle(1'b0, 3'd0, 32'h0, 1'b1);

    // Fill to full, drop the fifth, drain in order, then empty.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 3'(i), 32'(i), 1'b0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 3'd7, 32'd5, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 32'h0, 1'b1);
    chk("drained_valid", 64'(out_valid), 64'd0);

    // Full with out_ready high: push still refused, pop proceeds.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 3'(i), 32'h100 + 32'(i), 1'b0);
    cycle(1'b1, 3'd6, 32'hDEAD, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 32'h0, 1'b1);

    // Flags and parity.
    cycle(1'b1, 3'b010, 32'h0000_0000, 1'b0);
    cycle(1'b1, 3'b110, 32'h8000_0000, 1'b0);
    cycle(1'b1, 3'b001, 32'h0000_0007, 1'b0);
    cycle(1'b1, 3'b011, 32'h0000_0003, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 32'h0, 1'b1);

    // Concurrent push/pop at count=2 across several pointer wraps.
    cycle(1'b1, 3'd1, 32'hA000_0001, 1'b0);
    cycle(1'b1, 3'd2, 32'hA000_0002, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 3'(i), 32'hB000_0000 + 32'(i * 3), 1'b1);
    chk("conc_count", 64'(count), 64'd2);
    cycle(1'b0, 3'd0, 32'h0, 1'b1);

    // Asynchronous reset mid-stream at count=3.
    cycle(1'b1, 3'd3, 32'hC0DE_0003, 1'b0);
    cycle(1'b1, 3'd4, 32'hC0DE_0004, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd3);
    in_valid = 1'b1;
    in_y     = 32'hFFFF_FFFF;
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    sb.delete();
    #1;
    rst = 1'b0;
    cycle(1'b1, 3'd5, 32'h0000_00AB, 1'b0);
    cycle(1'b0, 3'd0, 32'h0, 1'b1);
    cycle(1'b0, 3'd0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
